// File: rtl/dma_copy_master.sv
// Block-copy bus master: one granted read then one granted write per 32-bit word.
// Optional macro DMA_FILL_EN adds fill_mode/fill_value (write a constant, skip reads).
module dma_copy_master #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  input  logic             irq_ack,
`ifdef DMA_FILL_EN
  input  logic             fill_mode,
  input  logic [31:0]      fill_value,
`endif
  input  logic             bus_gnt,
  output logic             rd,
  output logic             wr,
  output logic [31:0]      addr,
  output logic [31:0]      wdata,
  input  logic [31:0]      rdata,
  output logic             busy,
  output logic             done,
  output logic             irqout,
  output logic [LEN_W-1:0] words_left
);
  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [31:0]      r_src, r_dst, r_buf;
  logic [LEN_W-1:0] r_left;
  logic             r_irq;
  logic             w_fill, w_start_fill, w_launch, w_rd_go, w_wr_go, w_last;
  logic [31:0]      w_wsrc, w_src_al, w_dst_al;

`ifdef DMA_FILL_EN
  logic        r_fill;
  logic [31:0] r_fval;
  assign w_fill       = r_fill;
  assign w_start_fill = fill_mode;
  assign w_wsrc       = r_fill ? r_fval : r_buf;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fill <= 1'b0;
      r_fval <= '0;
    end else if (w_launch) begin
      r_fill <= fill_mode;
      r_fval <= fill_value;
    end
  end
`else
  assign w_fill       = 1'b0;
  assign w_start_fill = 1'b0;
  assign w_wsrc       = r_buf;
`endif

  assign w_src_al = src_addr & 32'hFFFF_FFFC;
  assign w_dst_al = dst_addr & 32'hFFFF_FFFC;
  assign w_launch = (r_state == S_IDLE) && start && (len != '0);
  // Abort suppresses all internal updates; the strobe itself still reaches the bus.
  assign w_rd_go  = (r_state == S_RD) && bus_gnt && !abort;
  assign w_wr_go  = (r_state == S_WR) && bus_gnt && !abort;
  assign w_last   = (r_left == LEN_W'(1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = (len == '0) ? S_DONE : (w_start_fill ? S_WR : S_RD);
      S_RD:   if (abort) w_state_nxt = S_IDLE;
              else if (bus_gnt) w_state_nxt = S_WR;
      S_WR:   if (abort) w_state_nxt = S_IDLE;
              else if (bus_gnt) w_state_nxt = w_last ? S_DONE : (w_fill ? S_WR : S_RD);
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_buf   <= '0;
      r_left  <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_launch) begin
        r_src  <= w_src_al;
        r_dst  <= w_dst_al;
        r_left <= len;
      end
      if (w_rd_go) begin
        r_buf <= rdata;
        r_src <= r_src + 32'd4;
      end
      if (w_wr_go) begin
        r_dst  <= r_dst + 32'd4;
        r_left <= r_left - LEN_W'(1);
      end
      // Entry into DONE takes priority over a simultaneous acknowledge.
      if (w_state_nxt == S_DONE) r_irq <= 1'b1;
      else if (irq_ack)          r_irq <= 1'b0;
    end
  end

  always_comb begin
    rd    = 1'b0;
    wr    = 1'b0;
    addr  = '0;
    wdata = '0;
    if (bus_gnt) begin
      if (r_state == S_RD) begin
        rd   = 1'b1;
        addr = r_src;
      end else if (r_state == S_WR) begin
        wr    = 1'b1;
        addr  = r_dst;
        wdata = w_wsrc;
      end
    end
  end

  assign busy       = (r_state == S_RD) || (r_state == S_WR);
  assign done       = (r_state == S_DONE);
  assign irqout     = r_irq;
  assign words_left = r_left;
endmodule

// File: tb/tb_dma_copy_master.sv
// Randomized bench for dma_copy_master: a word-memory responder plus a sequential copy model
// predicting the bus operation list, final memory image and completion cycle from the grant pattern.
module tb_dma_copy_master;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             reset, start, abort, irq_ack, bus_gnt;
  logic [31:0]      src_addr, dst_addr, rdata, addr, wdata;
  logic [LEN_W-1:0] len, words_left;
  logic             rd, wr, busy, done, irqout;

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];
  int          n_chk = 0, n_err = 0;
  int          cyc, quiet_err, both_err;
  int          ob_k[$];
  logic [31:0] ob_a[$], ob_d[$];
  int          done_at[$];

  always #5 clk = ~clk;

  assign rdata = mem[addr[11:2]];
  always @(posedge clk) if (wr) mem[addr[11:2]] <= wdata;

  dma_copy_master #(.LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .len(len), .abort(abort), .irq_ack(irq_ack), .bus_gnt(bus_gnt), .rd(rd), .wr(wr),
    .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done), .irqout(irqout),
    .words_left(words_left)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int idx(input logic [31:0] a);
    return int'(a[11:2]);
  endfunction

  task automatic clear_log();
    ob_k.delete(); ob_a.delete(); ob_d.delete(); done_at.delete();
    quiet_err = 0; both_err = 0;
  endtask

  // Entered at posedge+1: drive inputs, sample outputs, advance one clock.
  task automatic step(input logic g, input logic st, input logic ab, input logic ack);
    bus_gnt = g; start = st; abort = ab; irq_ack = ack;
    #1;
    if (rd && wr) both_err++;
    if ((!g || !busy) && (rd || wr || addr != 0 || wdata != 0)) quiet_err++;
    if (rd) begin ob_k.push_back(0); ob_a.push_back(addr); ob_d.push_back(rdata); end
    if (wr) begin ob_k.push_back(1); ob_a.push_back(addr); ob_d.push_back(wdata); end
    if (done) done_at.push_back(cyc);
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic do_copy(input logic [31:0] s, input logic [31:0] d, input int n, input int gprob,
                         input int st_at, input int st_len, input int re_at, input string nm);
    logic        gp [0:599];
    int          granted, k, exp_done, bad, m;
    logic [31:0] ra, wa, v, s_al, d_al;
    int          ek[$];
    logic [31:0] ea[$], ed[$];
    for (int i = 0; i < 600; i++) gp[i] = (i == 0) || ($urandom_range(0, 99) < gprob);
    for (int i = st_at; i < st_at + st_len; i++) gp[i] = 1'b0;
    // Each word needs two granted cycles; done shows the cycle after the last one.
    granted = 0; k = 1;
    while (granted < 2 * n && k < 599) begin
      if (gp[k]) granted++;
      k++;
    end
    exp_done = k;
    for (int i = 0; i < 1024; i++) ref_mem[i] = mem[i];
    s_al = s & 32'hFFFF_FFFC;
    d_al = d & 32'hFFFF_FFFC;
    for (int i = 0; i < n; i++) begin
      ra = s_al + 32'(4 * i);
      wa = d_al + 32'(4 * i);
      v  = ref_mem[idx(ra)];
      ek.push_back(0); ea.push_back(ra); ed.push_back(v);
      ek.push_back(1); ea.push_back(wa); ed.push_back(v);
      ref_mem[idx(wa)] = v;
    end
    clear_log();
    src_addr = s; dst_addr = d; len = LEN_W'(n);
    cyc = 0;
    step(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
    while (cyc <= exp_done + 2 && cyc < 600) begin
      if (cyc == re_at) begin
        src_addr = $urandom; dst_addr = $urandom; len = LEN_W'($urandom);
        step(gp[cyc], 1'b1, 1'b0, 1'b0);
        src_addr = s; dst_addr = d; len = LEN_W'(n);
      end else step(gp[cyc], 1'b0, 1'b0, 1'b0);
    end
    chk({nm, ":nops"}, 32'(ob_k.size()), 32'(ek.size()));
    m = (ob_k.size() < ek.size()) ? ob_k.size() : ek.size();
    for (int i = 0; i < m; i++) begin
      chk({nm, ":kind"}, 32'(ob_k[i]), 32'(ek[i]));
      chk({nm, ":addr"}, ob_a[i], ea[i]);
      chk({nm, ":data"}, ob_d[i], ed[i]);
    end
    chk({nm, ":ndone"}, 32'(done_at.size()), 32'd1);
    if (done_at.size() > 0) chk({nm, ":done_cyc"}, 32'(done_at[0]), 32'(exp_done));
    chk({nm, ":irq"}, 32'(irqout), 32'd1);
    chk({nm, ":busy"}, 32'(busy), 32'd0);
    chk({nm, ":left"}, 32'(words_left), 32'd0);
    chk({nm, ":quiet"}, 32'(quiet_err), 32'd0);
    chk({nm, ":rdwr"}, 32'(both_err), 32'd0);
    bad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk({nm, ":mem"}, 32'(bad), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk({nm, ":irq_ack"}, 32'(irqout), 32'd0);
  endtask

  initial begin
    logic [31:0] snap [0:1023];
    int          nw, nr;
    reset = 1'b0; start = 1'b0; abort = 1'b0; irq_ack = 1'b0; bus_gnt = 1'b1;
    src_addr = '0; dst_addr = '0; len = '0;
    for (int i = 0; i < 1024; i++) mem[i] <= $urandom;
    #2;
    chk("rst:rd", 32'(rd), 32'd0);
    chk("rst:wr", 32'(wr), 32'd0);
    chk("rst:addr", addr, 32'd0);
    chk("rst:wdata", wdata, 32'd0);
    chk("rst:busy", 32'(busy), 32'd0);
    chk("rst:done", 32'(done), 32'd0);
    chk("rst:irq", 32'(irqout), 32'd0);
    chk("rst:left", 32'(words_left), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    do_copy(32'h10, 32'h40, 3, 100, 0, 0, 0, "copy");
    do_copy(32'h80, 32'h90, 0, 100, 0, 0, 0, "len0");
    do_copy(32'h100, 32'h180, 2, 100, 2, 3, 0, "stall");
    do_copy(32'h13, 32'hFFFF_FFFE, 2, 100, 0, 0, 0, "wrap");
    do_copy(32'h20, 32'h60, 3, 100, 0, 0, 2, "restart");

    // Abort during the second read: one word written, count frozen at 3.
    for (int i = 0; i < 1024; i++) snap[i] = mem[i];
    clear_log();
    src_addr = 32'h200; dst_addr = 32'h300; len = LEN_W'(4);
    cyc = 0;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    nw = 0; nr = 0;
    foreach (ob_k[i]) if (ob_k[i] == 1) nw++; else nr++;
    chk("abort:writes", 32'(nw), 32'd1);
    chk("abort:reads", 32'(nr), 32'd2);
    chk("abort:ndone", 32'(done_at.size()), 32'd0);
    chk("abort:left", 32'(words_left), 32'd3);
    chk("abort:busy", 32'(busy), 32'd0);
    chk("abort:irq", 32'(irqout), 32'd0);
    chk("abort:w0", mem[idx(32'h300)], snap[idx(32'h200)]);
    chk("abort:w1", mem[idx(32'h304)], snap[idx(32'h304)]);

    for (int t = 0; t < 20; t++)
      do_copy($urandom, $urandom, int'($urandom_range(0, 12)), int'($urandom_range(50, 100)),
              0, 0, 0, "rand");

    // Reset mid-transfer with irqout already set.
    clear_log();
    len = '0; cyc = 0;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rstmid:irq_pre", 32'(irqout), 32'd1);
    src_addr = 32'h400; dst_addr = 32'h500; len = LEN_W'(5);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    #1 reset = 1'b0;
    #1;
    chk("rstmid:strobe", 32'({rd, wr}), 32'd0);
    chk("rstmid:addr", addr, 32'd0);
    chk("rstmid:busy", 32'(busy), 32'd0);
    chk("rstmid:left", 32'(words_left), 32'd0);
    chk("rstmid:irq", 32'(irqout), 32'd0);
    @(posedge clk); #1;
    clear_log();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rstmid:quiet", 32'(ob_k.size() + quiet_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/dma_copy_master.md
Name: dma_copy_master

Overview:
- Bus initiator for the CPU data bus, driving the same rd/wr/addr/wdata/rdata interface the data memory and peripherals respond on.
- Copies a block of 32-bit words from a source address to a destination address, one read followed by one write per word.
- An external arbiter's bus_gnt shares the bus with the CPU.
- Started by a one-cycle start pulse; reports completion with a done pulse and a sticky irqout.

Parameters:
LEN_W, 8, width of the word-count input and the words_left output (max 2^LEN_W-1 words)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  reset, asynchronous, active-low
start  input  1  one-cycle request; sampled only in IDLE
src_addr  input  32  source byte address; bits [1:0] ignored (forced 0)
dst_addr  input  32  destination byte address; bits [1:0] ignored (forced 0)
len  input  LEN_W  number of words to copy
abort  input  1  cancel the transfer in progress
irq_ack  input  1  clears irqout
bus_gnt  input  1  arbiter grant; bus outputs are active only while high
rd  output  1  bus read strobe
wr  output  1  bus write strobe
addr  output  32  bus address
wdata  output  32  bus write data
rdata  input  32  bus read data, combinational from responder in the same cycle
busy  output  1  high in RD and WR states
done  output  1  one-cycle completion pulse
irqout  output  1  sticky completion interrupt
words_left  output  LEN_W  remaining word count

Behaviour:
- Reset (async, reset=0): state=IDLE; all counters, address registers and buffers=0; busy=0, done=0, irqout=0, words_left=0; rd=wr=0, addr=0, wdata=0.
- States: IDLE, RD, WR, DONE.
- IDLE:
  - start=1 and len!=0: latch cur_src={src_addr[31:2],2'b00}, cur_dst likewise, words_left=len; go to RD.
  - start=1 and len=0: go to DONE with no bus activity.
- RD:
  - rd=bus_gnt, addr=cur_src while bus_gnt=1.
  - At an edge with bus_gnt=1: buf<=rdata, cur_src<=cur_src+4 (mod 2^32), go to WR.
  - bus_gnt=0: rd=0, addr=0, hold state (stall, any length).
- WR:
  - wr=bus_gnt, addr=cur_dst, wdata=buf while bus_gnt=1.
  - At an edge with bus_gnt=1: cur_dst<=cur_dst+4 (mod 2^32), words_left<=words_left-1; go to DONE if words_left was 1, else RD.
  - bus_gnt=0: stall as in RD.
- DONE: done=1 for exactly one cycle; irqout set to 1; return to IDLE.
- Outputs outside an active granted cycle: rd, wr, addr and wdata are 0. This keeps the bus quiet for other masters.
- rd and wr are never both 1.
- Word n costs exactly 2 granted cycles. With gnt held high, len=N gives done in cycle 2N+1 after the start edge.
- start while not in IDLE: ignored, with no effect on the latched parameters.
- abort=1 in RD or WR:
  - At the next edge: go to IDLE, words_left holds its current value, done and irqout not asserted.
  - A bus cycle presented during that abort cycle still completes at the responder.
- abort in IDLE/DONE: ignored. abort and start in the same IDLE cycle: start wins.
- irqout:
  - Set on entry to DONE; cleared when irq_ack=1.
  - Set and irq_ack in the same cycle: set wins.
- Reset mid-transfer: immediate return to reset values; no further bus strobes.

Optional Feature:
- Macro DMA_FILL_EN.
- When defined: adds inputs fill_mode (1) and fill_value (32).
  - Both are latched at the start edge.
  - With fill_mode=1, the FSM skips RD entirely: IDLE goes to WR, and WR goes to WR per word with wdata=fill_value.
  - len=N then completes in N+1 cycles; src_addr is unused.
- When undefined: these ports do not exist and behaviour is copy-only.

Test Plan:
- Copy: gnt=1, mem[0x10..0x18]=A,B,C; start src=0x10 dst=0x40 len=3 -> reads 0x10, 0x14, 0x18 alternate with writes 0x40, 0x44, 0x48. mem[0x40..0x48]=A,B,C. done in cycle 7 after start; irqout=1 until irq_ack.
- len=0 start -> no rd/wr ever; done pulse one cycle after start; irqout=1.
- Stall: len=2, bus_gnt low for 3 cycles during first WR -> wr=0, addr=0 during the stall; the write resumes with the same wdata; done at cycle 5+3=8.
- Abort: len=4, abort in the 3rd cycle (second RD) -> IDLE next edge, words_left=3, no done, irqout stays 0. Exactly one word written.
- Misalignment and wrap: src=0x13, dst=0xFFFFFFFE, len=2 -> reads 0x10, 0x14; writes 0xFFFFFFFC, then 0x00000000.
- Busy start: a second start during a transfer, with different src -> ignored; the transfer uses the original parameters.
